// File: rtl/coreabc_imem_apb_master_pkg.sv
// coreabc_imem_apb_master_pkg: state encoding, beat arithmetic and APB register offsets
package coreabc_imem_apb_master_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  localparam int ADDR_OFS = 0;
  function automatic int data_ofs(input int k);
    return 4 * k;
  endfunction
  function automatic int nbeats(input int iw, input int dw);
    return (iw + dw - 1) / dw;
  endfunction
  function automatic int beat_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/coreabc_imem_apb_master.sv
// coreabc_imem_apb_master: APB initiator moving whole instruction words to/from the instruction-store NVM
//  clk/rstn                            clock, synchronous active-low reset
//  req_valid/req_ready/req_write       request handshake (accepted only in IDLE)
//  req_addr/req_wdata                  instruction address and write word
//  rsp_valid/rsp_err/rsp_rdata         one-cycle completion pulse with status and read word
//  psel/penable/pwrite/paddr/pwdata    APB request side
//  prdata/pready/pslverr               APB completion side
module coreabc_imem_apb_master
  import coreabc_imem_apb_master_pkg::*;
#(
  parameter int AWIDTH  = 8,
  parameter int DWIDTH  = 8,
  parameter int ICWIDTH = 8,
  parameter int IWWIDTH = 58,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [ICWIDTH-1:0] req_addr,
  input  logic [IWWIDTH-1:0] req_wdata,
  output logic               rsp_valid,
  output logic               rsp_err,
  output logic [IWWIDTH-1:0] rsp_rdata,
  output logic               psel,
  output logic               penable,
  output logic               pwrite,
  output logic [AWIDTH-1:0]  paddr,
  output logic [DWIDTH-1:0]  pwdata,
  input  logic [DWIDTH-1:0]  prdata,
  input  logic               pready,
  input  logic               pslverr
);
  localparam int NB = nbeats(IWWIDTH, DWIDTH);
  localparam int BW = beat_w(NB);
  localparam int TW = $clog2(TIMEOUT + 2);
  localparam int PW = NB * DWIDTH;
  state_t st, nxt;
  logic [BW-1:0] beat, idx;
  logic [TW-1:0] tcnt;
  logic wr, err, last, tmo, cap;
  logic [ICWIDTH-1:0] addr;
  logic [PW-1:0] wdata;
  logic [IWWIDTH-1:0] rdata;
  // beat 0 carries the address; data beat k moves chunk k-1
  assign idx = beat == '0 ? '0 : beat - 1'b1;
  assign last = int'(beat) == NB;
  // never true when TIMEOUT is 0, which disables the timeout
  assign tmo = !pready && int'(tcnt) + 1 == TIMEOUT;
  assign cap = st == ACCESS && pready && !pslverr && !wr && beat != '0;
  assign req_ready = st == IDLE;
  assign psel = st == SETUP || st == ACCESS;
  assign penable = st == ACCESS;
  assign pwrite = psel && (beat == '0 || wr);
  assign paddr = !psel ? '0 : beat == '0 ? AWIDTH'(ADDR_OFS) : AWIDTH'(data_ofs(int'(beat)));
  assign pwdata = !psel ? '0 : beat == '0 ? DWIDTH'(addr) : wdata[int'(idx)*DWIDTH +: DWIDTH];
  assign rsp_valid = st == RESP;
  assign rsp_err = rsp_valid && err;
  assign rsp_rdata = rdata;
  always_comb begin
    nxt = st;
    case (st)
      IDLE:    nxt = req_valid ? SETUP : IDLE;
      SETUP:   nxt = ACCESS;
      ACCESS:  nxt = pready ? (pslverr || last ? RESP : SETUP) : (tmo ? RESP : ACCESS);
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      st <= IDLE;
      beat <= '0;
      tcnt <= '0;
      wr <= 1'b0;
      err <= 1'b0;
      addr <= '0;
      wdata <= '0;
      rdata <= '0;
    end else begin
      st <= nxt;
      if (st == IDLE && req_valid) begin
        wr <= req_write;
        addr <= req_addr;
        wdata <= PW'(req_wdata);
        rdata <= '0;
        err <= 1'b0;
        beat <= '0;
      end
      if (st == SETUP) tcnt <= '0;
      if (st == ACCESS) begin
        err <= pready ? pslverr : tmo;
        if (pready) beat <= beat + 1'b1;
        else tcnt <= tcnt + 1'b1;
      end
      // pad bits of the last chunk have no destination and are dropped here
      for (int i = 0; i < IWWIDTH; i++)
        if (cap && int'(idx) == i / DWIDTH) rdata[i] <= prdata[i % DWIDTH];
    end
  end
endmodule

// File: tb/tb_coreabc_imem_apb_master.sv
// tb_coreabc_imem_apb_master: table-driven scoreboard bench for the instruction-word APB initiator
module tb_coreabc_imem_apb_master;
  typedef struct {
    logic [7:0] a;
    logic       w;
    logic [7:0] d;
    bit         cd;
  } apb_t;
  typedef struct {
    logic        e;
    logic [57:0] r;
    bit          rd;
    int          lat;
  } rsp_t;
  typedef struct {
    bit          wr;
    logic [7:0]  addr;
    logic [57:0] wdata;
    logic [7:0]  seed;
    int          stall_beat;
    int          stall_n;
    int          err_beat;
    int          stuck_beat;
    int          nd;
    bit          err;
    logic [57:0] rdata;
    int          lat;
  } req_t;

  logic clk = 1'b0, rstn = 1'b0;
  logic req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [7:0] req_addr = '0;
  logic [57:0] req_wdata = '0;
  logic rsp_valid, rsp_err;
  logic [57:0] rsp_rdata;
  logic psel, penable, pwrite;
  logic [7:0] paddr, pwdata;
  logic [7:0] prdata = '0;
  logic pready = 1'b1, pslverr = 1'b0;

  apb_t exp_apb[$];
  rsp_t exp_rsp[$];
  req_t tbl[10];
  int errors = 0, checks = 0;
  int pcyc = 0, acc = 0, rsp_seen = 0;
  int stall_beat = -1, stall_n = 0, waited = 0, err_beat = -1, stuck_beat = -1;
  logic [7:0] seed = '0;
  logic [7:0] s_addr = '0, s_data = '0;
  logic s_wr = 1'b0;
  int mk;
  apb_t ma;
  rsp_t mr;

  coreabc_imem_apb_master #(.TIMEOUT(4)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) pcyc <= pcyc + 1;

  function automatic void chk(string n, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", n, got, exp);
    end
  endfunction

  // slave model and monitors, all acting on the falling edge
  initial forever begin
    @(negedge clk);
    pready = 1'b1;
    pslverr = 1'b1;
    prdata = 8'hFF;
    if (psel && !penable) begin
      s_addr = paddr;
      s_data = pwdata;
      s_wr = pwrite;
    end
    if (psel && penable) begin
      mk = int'(paddr) / 4;
      if (mk == stall_beat && waited < stall_n) begin
        pready = 1'b0;
        waited++;
      end else if (mk == stuck_beat) pready = 1'b0;
      pslverr = mk == err_beat;
      prdata = 8'(mk * 17) ^ seed;
      chk("stable_paddr", 64'(paddr), 64'(s_addr));
      chk("stable_pwdata", 64'(pwdata), 64'(s_data));
      chk("stable_pwrite", 64'(pwrite), 64'(s_wr));
      if (pready) begin
        if (exp_apb.size() == 0) chk("apb_pending", 64'(exp_apb.size()), 1);
        else begin
          ma = exp_apb.pop_front();
          chk("apb_paddr", 64'(paddr), 64'(ma.a));
          chk("apb_pwrite", 64'(pwrite), 64'(ma.w));
          if (ma.cd) chk("apb_pwdata", 64'(pwdata), 64'(ma.d));
        end
      end
    end
    if (rsp_valid) begin
      rsp_seen++;
      if (exp_rsp.size() == 0) chk("rsp_pending", 64'(exp_rsp.size()), 1);
      else begin
        mr = exp_rsp.pop_front();
        chk("rsp_err", 64'(rsp_err), 64'(mr.e));
        if (mr.rd) chk("rsp_rdata", 64'(rsp_rdata), 64'(mr.r));
        chk("rsp_latency", 64'(pcyc - acc), 64'(mr.lat));
        chk("rsp_psel", 64'(psel), 0);
      end
    end
  end

  task automatic start_req(input req_t t);
    apb_t ta;
    rsp_t tr;
    logic [63:0] pad;
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_idle", 64'(req_ready), 1);
    stall_beat = t.stall_beat;
    stall_n = t.stall_n;
    waited = 0;
    err_beat = t.err_beat;
    stuck_beat = t.stuck_beat;
    seed = t.seed;
    pad = 64'(t.wdata);
    for (int k = 0; k < t.nd; k++) begin
      ta.a = 8'(k * 4);
      if (k == 0) begin
        ta.w = 1'b1;
        ta.d = t.addr;
        ta.cd = 1'b1;
      end else begin
        ta.w = t.wr;
        ta.d = pad[(k-1)*8 +: 8];
        ta.cd = t.wr;
      end
      exp_apb.push_back(ta);
    end
    tr = '{t.err, t.rdata, !t.wr, t.lat};
    exp_rsp.push_back(tr);
    req_valid = 1'b1;
    req_write = t.wr;
    req_addr = t.addr;
    req_wdata = t.wdata;
    @(posedge clk);
    #1;
    acc = pcyc;
    req_valid = 1'b0;
    req_write = !t.wr;
    req_addr = ~t.addr;
    req_wdata = ~t.wdata;
  endtask

  task automatic finish_req();
    int n, s0;
    n = 0;
    s0 = rsp_seen;
    while (rsp_seen == s0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_arrived", 64'(rsp_seen - s0), 1);
    @(negedge clk);
    chk("req_ready_after", 64'(req_ready), 1);
    chk("apb_all_done", 64'(exp_apb.size()), 0);
    exp_apb.delete();
  endtask

  initial begin
    int n, s0;
    //        wr addr   wdata                   seed   stall  err st nd err rdata                    lat
    tbl[0] = '{1, 8'h15, 58'h2AB_CDEF_0123_4567, 8'h00, -1, 0, -1, -1, 9, 0, 58'h0,                  18};
    tbl[1] = '{0, 8'h80, 58'h0,                  8'h00, -1, 0, -1, -1, 9, 0, 58'h0077_6655_4433_2211, 18};
    tbl[2] = '{1, 8'h3C, 58'h155_5555_AAAA_5555, 8'h00,  4, 3, -1, -1, 9, 0, 58'h0,                  21};
    tbl[3] = '{0, 8'h22, 58'h0,                  8'h00, -1, 0,  2, -1, 3, 1, 58'h11,                  6};
    tbl[4] = '{0, 8'h7F, 58'h0,                  8'h00, -1, 0, -1,  3, 3, 1, 58'h2211,               11};
    tbl[5] = '{0, 8'hFF, 58'h0,                  8'hFF, -1, 0, -1, -1, 9, 0, 58'h388_99AA_BBCC_DDEE, 18};
    tbl[6] = '{1, 8'h00, 58'h3FF_FFFF_FFFF_FFFF, 8'h00, -1, 0, -1, -1, 9, 0, 58'h0,                  18};
    tbl[7] = '{0, 8'h5A, 58'h0,                  8'hA5,  0, 2, -1, -1, 9, 0, 58'h1D2_C3F0_E196_87B4, 20};
    tbl[8] = '{1, 8'h01, 58'h123,                8'h00, -1, 0,  0, -1, 1, 1, 58'h0,                   2};
    tbl[9] = '{0, 8'h99, 58'h0,                  8'hFF, -1, 0,  8, -1, 9, 1, 58'h0088_99AA_BBCC_DDEE, 18};
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 1);
    chk("rst_psel", 64'(psel), 0);
    chk("rst_penable", 64'(penable), 0);
    chk("rst_pwrite", 64'(pwrite), 0);
    chk("rst_rsp_valid", 64'(rsp_valid), 0);
    chk("rst_rsp_err", 64'(rsp_err), 0);
    chk("rst_paddr", 64'(paddr), 0);
    chk("rst_pwdata", 64'(pwdata), 0);
    chk("rst_rsp_rdata", 64'(rsp_rdata), 0);
    rstn = 1'b1;
    for (int r = 0; r < 10; r++) begin
      start_req(tbl[r]);
      finish_req();
    end
    start_req(tbl[1]);
    n = 0;
    @(negedge clk);
    while (!(psel && !penable && paddr == 8'd20) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("beat5_reached", 64'(paddr), 20);
    rstn = 1'b0;
    exp_apb.delete();
    exp_rsp.delete();
    s0 = rsp_seen;
    @(negedge clk);
    chk("abort_psel", 64'(psel), 0);
    chk("abort_penable", 64'(penable), 0);
    chk("abort_req_ready", 64'(req_ready), 1);
    chk("abort_rsp_valid", 64'(rsp_valid), 0);
    rstn = 1'b1;
    repeat (30) @(negedge clk);
    chk("abort_no_rsp", 64'(rsp_seen), 64'(s0));
    start_req(tbl[0]);
    finish_req();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
